// File: rtl/hack_spi_pkg.sv
// hack_spi_pkg: shared SPI frame constants and loader states.
// Used by the programming loader and the CPU-side SPI slave.
package hack_spi_pkg;

  localparam logic [7:0] CMD_WRITE = 8'h02;
  localparam logic [7:0] CMD_READ  = 8'h03;

  localparam int FRAME_BITS   = 40;
  localparam int DATA_LSB_BIT = 24;
  localparam int RX_BITS      = FRAME_BITS - DATA_LSB_BIT;
  localparam int BIT_CNT_W    = 6;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_SHIFT,
    ST_HOLD,
    ST_DONE
  } spi_ld_state_t;

  typedef struct packed {
    logic [7:0]  cmd;
    logic [15:0] addr;
    logic [15:0] data;
  } spi_frame_t;

  function automatic spi_frame_t mk_frame(
    input logic        is_read,
    input logic [15:0] addr,
    input logic [15:0] data
  );
    spi_frame_t f;
    f.cmd  = is_read ? CMD_READ : CMD_WRITE;
    f.addr = addr;
    f.data = is_read ? 16'h0000 : data;
    return f;
  endfunction

endpackage

// File: rtl/spi_prog_loader_sclk_div.sv
// spi_sclk_div: phase counter for the SPI loader.
// Strobes phase_end once every CLK_DIV enabled cycles.
module spi_sclk_div #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  output logic phase_end
);

  localparam logic [7:0] LAST = 8'(CLK_DIV - 1);

  logic [7:0] cnt;

  assign phase_end = en && (cnt == LAST);

  // count cycles within a phase; restart when idle or at phase end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (!en || phase_end) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 8'd1;
    end
  end

endmodule

// File: rtl/spi_prog_loader.sv
// spi_prog_loader: SPI mode-0 master for the Hack CPU program port.
// Define LOADER_READBACK_EN to enable read commands and rsp_rdata.
module spi_prog_loader
  import hack_spi_pkg::*;
#(
  parameter int CLK_DIV = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [15:0] req_addr,
  input  logic [15:0] req_wdata,
  output logic        rsp_valid,
  output logic [15:0] rsp_rdata,
  output logic        csb_o,
  output logic        sclk_o,
  output logic        mo_o,
  input  logic        mi_i,
  output logic        halt_o
);

  localparam logic [BIT_CNT_W-1:0] LAST_BIT =
    BIT_CNT_W'(FRAME_BITS);
  localparam logic [BIT_CNT_W-1:0] HOLD_END =
    BIT_CNT_W'(FRAME_BITS + 1);

  spi_ld_state_t state, state_n;

  logic [FRAME_BITS-1:0] sr, sr_n;
  logic [FRAME_BITS-1:0] frame;
  logic [BIT_CNT_W-1:0]  bit_cnt, cnt_n;

  logic csb_n, sclk_n, mo_n, halt_n, rv_n;
  logic div_en, phase_end;
  logic accept, sample_en, done_en;

  assign req_ready = (state == ST_IDLE);
  assign accept    = req_valid && req_ready;

  assign div_en = (state == ST_SETUP) ||
                  (state == ST_SHIFT) ||
                  (state == ST_HOLD);

  assign sample_en = (state == ST_SHIFT) &&
                     phase_end && sclk_o;

  assign done_en = (state == ST_HOLD) &&
                   phase_end && (bit_cnt == HOLD_END);

`ifdef LOADER_READBACK_EN
  assign frame = mk_frame(!req_write, req_addr, req_wdata);
`else
  assign frame = mk_frame(1'b0, req_addr, req_wdata);
`endif

  spi_sclk_div #(
    .CLK_DIV (CLK_DIV)
  ) u_div (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (div_en),
    .phase_end (phase_end)
  );

  // state, shift register and registered pin outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      sr        <= '0;
      bit_cnt   <= '0;
      csb_o     <= 1'b1;
      sclk_o    <= 1'b0;
      mo_o      <= 1'b0;
      halt_o    <= 1'b0;
      rsp_valid <= 1'b0;
    end else begin
      state     <= state_n;
      sr        <= sr_n;
      bit_cnt   <= cnt_n;
      csb_o     <= csb_n;
      sclk_o    <= sclk_n;
      mo_o      <= mo_n;
      halt_o    <= halt_n;
      rsp_valid <= rv_n;
    end
  end

  // frame sequencing driven by the phase strobe
  always_comb begin
    state_n = state;
    sr_n    = sr;
    cnt_n   = bit_cnt;
    csb_n   = csb_o;
    sclk_n  = sclk_o;
    mo_n    = mo_o;
    rv_n    = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (req_valid) begin
          state_n = ST_SETUP;
          sr_n    = frame;
          cnt_n   = '0;
          csb_n   = 1'b0;
          mo_n    = frame[FRAME_BITS-1];
        end
      end
      ST_SETUP: begin
        if (phase_end) begin
          state_n = ST_SHIFT;
          sclk_n  = 1'b1;
        end
      end
      ST_SHIFT: begin
        if (phase_end) begin
          if (sclk_o) begin
            sclk_n = 1'b0;
            sr_n   = {sr[FRAME_BITS-2:0], 1'b0};
            mo_n   = sr[FRAME_BITS-2];
            cnt_n  = bit_cnt + 1'b1;
          end else if (bit_cnt == LAST_BIT) begin
            state_n = ST_HOLD;
            csb_n   = 1'b1;
            mo_n    = 1'b0;
          end else begin
            sclk_n = 1'b1;
          end
        end
      end
      ST_HOLD: begin
        if (phase_end) begin
          if (bit_cnt == HOLD_END) begin
            state_n = ST_DONE;
            rv_n    = 1'b1;
          end else begin
            cnt_n = bit_cnt + 1'b1;
          end
        end
      end
      ST_DONE: begin
        state_n = ST_IDLE;
      end
      default: begin
        state_n = ST_IDLE;
      end
    endcase
    halt_n = (state_n != ST_IDLE);
  end

`ifdef LOADER_READBACK_EN
  logic               rd_q;
  logic [RX_BITS-1:0] rx_sr;

  // capture mi_i; the last RX_BITS samples are the data field
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_q      <= 1'b0;
      rx_sr     <= '0;
      rsp_rdata <= '0;
    end else begin
      if (accept) begin
        rd_q <= !req_write;
      end
      if (sample_en) begin
        rx_sr <= {rx_sr[RX_BITS-2:0], mi_i};
      end
      if (done_en) begin
        rsp_rdata <= rd_q ? rx_sr : '0;
      end
    end
  end
`else
  logic unused_rb;

  assign rsp_rdata = '0;
  assign unused_rb = &{1'b0, mi_i, req_write,
                       sample_en, accept, done_en};
`endif

endmodule
